// File: rtl/xbar_burst_arbiter.sv
// Round-robin burst arbiter that shares one output-memory port among NPORT crossbar requesters.
// Optional macro XBAR_ARB_BACK2BACK_EN: re-arbitrate on the last beat so that bursts can run back to back.
module xbar_burst_arbiter #(
  parameter int NPORT     = 4,
  parameter int ADDR_W    = 10,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORT-1:0]  req,
  output logic [NPORT-1:0]  gnt,
  output logic              cen,
  output logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              busy
);

  localparam int PID_W  = $clog2(NPORT);
  localparam int OFF_W  = ADDR_W - PID_W;
  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BURST_LEN - 1);
  localparam logic [OFF_W-1:0]  OFF_STEP  = OFF_W'(BURST_LEN);

  logic [1:0]       state_r;
  logic [PID_W-1:0] winner_r;
  logic [PID_W-1:0] rr_ptr_r;
  logic [BCNT_W-1:0] beat_r;
  logic [OFF_W-1:0] ptr_r [NPORT];

  logic             arb_valid_s;
  logic [PID_W-1:0] arb_idx_s;
  logic [PID_W-1:0] arb_base_s;
  logic [PID_W:0]   arb_sum_s;

  logic [NPORT-1:0]  gnt_s;
  logic              cen_s;
  logic              start_s;
  logic [ADDR_W-1:0] addr_s;
  logic              last_s;
  logic              busy_s;

  function automatic logic [PID_W-1:0] next_port(input logic [PID_W-1:0] p);
    if (int'(p) == NPORT - 1) begin
      return '0;
    end else begin
      return p + PID_W'(1);
    end
  endfunction

  // Round-robin pick: scan downwards so the lowest distance from the base wins.
  always_comb begin
    arb_base_s  = (state_r == ST_BURST) ? next_port(winner_r) : rr_ptr_r;
    arb_valid_s = 1'b0;
    arb_idx_s   = '0;
    arb_sum_s   = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      arb_sum_s = {1'b0, arb_base_s} + (PID_W + 1)'(i);
      if (arb_sum_s >= (PID_W + 1)'(NPORT)) begin
        arb_sum_s = arb_sum_s - (PID_W + 1)'(NPORT);
      end else begin
        arb_sum_s = arb_sum_s;
      end
      if (req[arb_sum_s[PID_W-1:0]]) begin
        arb_valid_s = 1'b1;
        arb_idx_s   = arb_sum_s[PID_W-1:0];
      end else begin
        arb_valid_s = arb_valid_s;
      end
    end
  end

  // Sequencer state, per-port write pointers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      winner_r <= '0;
      rr_ptr_r <= '0;
      beat_r   <= '0;
      for (int p = 0; p < NPORT; p++) ptr_r[p] <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          beat_r <= '0;
          if (arb_valid_s) begin
            state_r  <= ST_SETUP;
            winner_r <= arb_idx_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state_r <= ST_BURST;
          beat_r  <= '0;
        end
        ST_BURST: begin
          if (beat_r == BEAT_LAST) begin
            ptr_r[winner_r] <= ptr_r[winner_r] + OFF_STEP;
            rr_ptr_r        <= next_port(winner_r);
            beat_r          <= '0;
`ifdef XBAR_ARB_BACK2BACK_EN
            if (arb_valid_s) begin
              state_r  <= ST_SETUP;
              winner_r <= arb_idx_s;
            end else begin
              state_r <= ST_IDLE;
            end
`else
            state_r <= ST_IDLE;
`endif
          end else begin
            beat_r <= beat_r + BCNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          beat_r  <= '0;
        end
      endcase
    end
  end

  // Output values for the current sequencer state; registered below.
  always_comb begin
    gnt_s   = '0;
    cen_s   = 1'b0;
    start_s = 1'b0;
    addr_s  = '0;
    last_s  = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      ST_SETUP: begin
        gnt_s  = {{(NPORT-1){1'b0}}, 1'b1} << winner_r;
        cen_s  = 1'b1;
        busy_s = 1'b1;
        addr_s = {winner_r, ptr_r[winner_r]};
      end
      ST_BURST: begin
        gnt_s   = {{(NPORT-1){1'b0}}, 1'b1} << winner_r;
        cen_s   = 1'b1;
        start_s = 1'b1;
        busy_s  = 1'b1;
        addr_s  = {winner_r, ptr_r[winner_r] + OFF_W'(beat_r)};
        last_s  = (beat_r == BEAT_LAST);
      end
      default: begin
        gnt_s = '0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt   <= '0;
      cen   <= 1'b0;
      start <= 1'b0;
      addr  <= '0;
      last  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      gnt   <= gnt_s;
      cen   <= cen_s;
      start <= start_s;
      addr  <= addr_s;
      last  <= last_s;
      busy  <= busy_s;
    end
  end

endmodule

// File: tb/tb_xbar_burst_arbiter.sv
// Directed self-checking bench for xbar_burst_arbiter (NPORT=4, ADDR_W=10, BURST_LEN=4).
// Gap/period expectations follow XBAR_ARB_BACK2BACK_EN when the bench is built with it.
module tb_xbar_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       cen;
  logic       start;
  logic [9:0] addr;
  logic       last;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int setup_t  = 0;
  int t0       = 0;

  xbar_burst_arbiter #(.NPORT(4), .ADDR_W(10), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .cen(cen),
    .start(start), .addr(addr), .last(last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check(tag, {14'd0, gnt, cen, start, last, busy, addr}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 4'h0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // One burst: SETUP then four beats, optional req drop / reset at a beat, then one gap cycle.
  task automatic do_burst(input int port, input int off, input int drop_at, input int rst_at);
    logic [9:0] a;
    logic [3:0] g;
    for (int i = 0; i < 20 && gnt == 4'h0; i++) tick();
    check("setup_seen", {31'd0, gnt != 4'h0}, 32'd1);
    if (gnt == 4'h0) return;
    setup_t = cyc_cnt;
    g = 4'b0001 << port;
    a = {port[1:0], off[7:0]};
    check("setup_gnt", gnt, g);
    check("setup_ctl", {cen, start, last, busy}, 4'b1001);
    check("setup_addr", addr, a);
    for (int k = 0; k < 4; k++) begin
      tick();
      a = {port[1:0], 8'(off + k)};
      check("beat_gnt", gnt, g);
      check("beat_addr", addr, a);
      check("beat_ctl", {cen, start, last, busy}, {1'b1, 1'b1, k == 3, 1'b1});
      if (k == drop_at) req = 4'h0;
      if (k == rst_at) begin
        rst = 1'b0;
        return;
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset");
    end

    // Single port, two consecutive bursts, then stop.
    rst = 1'b1;
    req = 4'b0100;
    do_burst(2, 0, -1, -1);
    do_burst(2, 4, 2, -1);
    tick();
    tick();
    check_idle("single_idle");

    // Fairness with all ports requesting.
    do_reset();
    req = 4'hF;
    for (int n = 0; n < 8; n++) do_burst(n % 4, (n / 4) * 4, (n == 7) ? 2 : -1, -1);
    tick();
    tick();
    check_idle("fair_idle");

    // Offset wrap inside the port 1 region.
    do_reset();
    req = 4'b0010;
    for (int n = 0; n < 65; n++) do_burst(1, (n * 4) % 256, (n == 64) ? 2 : -1, -1);
    tick();
    tick();
    check_idle("wrap_idle");

    // Reset mid-burst, then a burst with req dropped at beat 1.
    do_reset();
    req = 4'b0001;
    do_burst(0, 0, -1, 2);
    tick();
    check_idle("rst_abort");
    rst = 1'b1;
    do_burst(0, 0, 1, -1);
    tick();
    tick();
    check_idle("drop_idle");
    req = 4'b0001;
    do_burst(0, 4, 2, -1);

    // Burst period and cen gap between two requesters.
    do_reset();
    req = 4'b0011;
    do_burst(0, 0, -1, -1);
`ifdef XBAR_ARB_BACK2BACK_EN
    check("gap_cen", {31'd0, cen}, 32'd1);
`else
    check("gap_cen", {31'd0, cen}, 32'd0);
`endif
    t0 = setup_t;
    do_burst(1, 0, 2, -1);
`ifdef XBAR_ARB_BACK2BACK_EN
    check("period", setup_t - t0, 32'd5);
`else
    check("period", setup_t - t0, 32'd6);
`endif
    tick();
    tick();
    check_idle("final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
